// File: rtl/riscv_m_unit_param_if.sv
// PCPI request/response bundle between the host core (master) and the M unit (slave).
interface riscv_m_unit_param_if;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        wr;
  logic [31:0] rd;
  logic        busy;
  logic        ready;

  modport master (output valid, instruction, rs1, rs2, input wr, rd, busy, ready);
  modport slave  (input valid, instruction, rs1, rs2, output wr, rd, busy, ready);
endinterface

// File: rtl/riscv_m_unit_param.sv
// RV32M coprocessor on PCPI: pipelined multiplier, radix-configurable restoring
// divider, divide fast paths and a single-entry quotient/remainder reuse cache.
//
// state | meaning
// IDLE  | waiting for a decoded M instruction
// MUL   | product moving through MUL_STAGES pipeline registers
// DIV   | 32/DIV_BITS restoring iterations, then one sign-fixup cycle
// FAST  | result resolved at accept, one cycle of latency
// DONE  | ready/wr pulse with rd valid
// COOL  | ignore the host's trailing valid for one cycle
module riscv_m_unit_param #(
  parameter int MUL_STAGES       = 1,
  parameter int DIV_BITS         = 1,
  parameter int ENABLE_EARLY_OUT = 1,
  parameter int ENABLE_REUSE     = 1
) (
  input logic                 clk,
  input logic                 resetn,
  riscv_m_unit_param_if.slave pcpi
);

  localparam int         DIV_ITERS    = 32 / DIV_BITS;
  localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_STAGES - 1);
  localparam logic [5:0] DIV_CNT_INIT = 6'(DIV_ITERS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FAST,
    S_DONE,
    S_COOL
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [31:0] rs1_q, rs2_q;
  logic [2:0]  f3_q;
  logic [32:0] mul_a_q, mul_b_q;
  logic [63:0] mul_pipe_q [MUL_STAGES];
  logic [31:0] rem_q, quo_q, dvs_q;
  logic [31:0] quo_res_q, rem_res_q;
  logic [31:0] c_quo_q, c_rem_q;
  logic        cache_hit;

  // Decode and accept
  logic [2:0]  f3_in;
  logic        dec_hit;
  logic        accept;
  logic        unused_instr;

  assign f3_in        = pcpi.instruction[14:12];
  assign dec_hit      = (pcpi.instruction[6:0] == 7'b0110011) &&
                        (pcpi.instruction[31:25] == 7'b0000001);
  assign unused_instr = ^{pcpi.instruction[24:15], pcpi.instruction[11:7]};
  assign accept       = (state_q == S_IDLE) && pcpi.valid && dec_hit;

  logic        in_is_div, in_sgn;
  logic        a_sgn_in, b_sgn_in;
  logic [31:0] abs1, abs2;

  assign in_is_div = f3_in[2];
  assign in_sgn    = ~f3_in[0];
  assign a_sgn_in  = (f3_in[1:0] != 2'b11);
  assign b_sgn_in  = ~f3_in[1];
  assign abs1      = (in_sgn && pcpi.rs1[31]) ? (32'd0 - pcpi.rs1) : pcpi.rs1;
  assign abs2      = (in_sgn && pcpi.rs2[31]) ? (32'd0 - pcpi.rs2) : pcpi.rs2;

  // Fast paths, resolved entirely at accept
  logic        f_div0, f_ovf, f_early, fast_hit;
  logic [31:0] fast_quo, fast_rem;

  assign f_div0   = (pcpi.rs2 == 32'd0);
  assign f_ovf    = in_sgn && (pcpi.rs1 == 32'h8000_0000) && (pcpi.rs2 == 32'hFFFF_FFFF);
  assign f_early  = (ENABLE_EARLY_OUT != 0) && (abs1 < abs2);
  assign fast_hit = f_div0 || f_ovf || cache_hit || f_early;

  always_comb begin
    fast_quo = '0;
    fast_rem = '0;
    if (f_div0) begin
      fast_quo = 32'hFFFF_FFFF;
      fast_rem = pcpi.rs1;
    end else if (f_ovf) begin
      fast_quo = 32'h8000_0000;
      fast_rem = '0;
    end else if (cache_hit) begin
      fast_quo = c_quo_q;
      fast_rem = c_rem_q;
    end else if (f_early) begin
      fast_quo = '0;
      fast_rem = pcpi.rs1;
    end
  end

  // FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!in_is_div) begin
            state_d = S_MUL;
            cnt_d   = MUL_CNT_INIT;
          end else if (fast_hit) begin
            state_d = S_FAST;
          end else begin
            state_d = S_DIV;
            cnt_d   = DIV_CNT_INIT;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (!pcpi.valid)        state_d = S_IDLE;
        else if (cnt_q == 6'd0) state_d = S_DONE;
        else                    cnt_d   = cnt_q - 6'd1;
      end
      S_FAST:  state_d = pcpi.valid ? S_DONE : S_IDLE;
      S_DONE:  state_d = S_COOL;
      S_COOL:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier: sign/zero-extended 33x33 product, low 64 bits kept
  logic [63:0] mul_prod;
  assign mul_prod = {{31{mul_a_q[32]}}, mul_a_q} * {{31{mul_b_q[32]}}, mul_b_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < MUL_STAGES; k++) mul_pipe_q[k] <= '0;
    end else if (state_q == S_MUL) begin
      mul_pipe_q[0] <= mul_prod;
      for (int k = 1; k < MUL_STAGES; k++) mul_pipe_q[k] <= mul_pipe_q[k-1];
    end
  end

  // Restoring divider: quo_q shifts the dividend out while quotient bits shift in
  logic [31:0] div_rem_nxt, div_quo_nxt;
  logic [32:0] trial;

  always_comb begin
    div_rem_nxt = rem_q;
    div_quo_nxt = quo_q;
    trial       = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      trial       = {div_rem_nxt, div_quo_nxt[31]};
      div_quo_nxt = {div_quo_nxt[30:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial          = trial - {1'b0, dvs_q};
        div_quo_nxt[0] = 1'b1;
      end
      div_rem_nxt = trial[31:0];
    end
  end

  logic q_neg, r_neg;
  assign q_neg = ~f3_q[0] & (rs1_q[31] ^ rs2_q[31]);
  assign r_neg = ~f3_q[0] & rs1_q[31];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      f3_q      <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      quo_res_q <= '0;
      rem_res_q <= '0;
    end else if (accept) begin
      rs1_q     <= pcpi.rs1;
      rs2_q     <= pcpi.rs2;
      f3_q      <= f3_in;
      mul_a_q   <= {a_sgn_in & pcpi.rs1[31], pcpi.rs1};
      mul_b_q   <= {b_sgn_in & pcpi.rs2[31], pcpi.rs2};
      rem_q     <= '0;
      quo_q     <= abs1;
      dvs_q     <= abs2;
      quo_res_q <= fast_quo;
      rem_res_q <= fast_rem;
    end else if (state_q == S_DIV) begin
      if (cnt_q != 6'd0) begin
        rem_q <= div_rem_nxt;
        quo_q <= div_quo_nxt;
      end else begin
        quo_res_q <= q_neg ? (32'd0 - quo_q) : quo_q;
        rem_res_q <= r_neg ? (32'd0 - rem_q) : rem_q;
      end
    end
  end

  // Reuse cache: captured in DONE so aborted divides never populate it
  if (ENABLE_REUSE != 0) begin : g_reuse
    logic        c_valid_q;
    logic        c_sgn_q;
    logic [31:0] c_rs1_q, c_rs2_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        c_valid_q <= 1'b0;
        c_sgn_q   <= 1'b0;
        c_rs1_q   <= '0;
        c_rs2_q   <= '0;
        c_quo_q   <= '0;
        c_rem_q   <= '0;
      end else if ((state_q == S_DONE) && f3_q[2]) begin
        c_valid_q <= 1'b1;
        c_sgn_q   <= ~f3_q[0];
        c_rs1_q   <= rs1_q;
        c_rs2_q   <= rs2_q;
        c_quo_q   <= quo_res_q;
        c_rem_q   <= rem_res_q;
      end
    end

    assign cache_hit = c_valid_q && (c_rs1_q == pcpi.rs1) && (c_rs2_q == pcpi.rs2) &&
                       (c_sgn_q == in_sgn);
  end else begin : g_no_reuse
    assign c_quo_q   = '0;
    assign c_rem_q   = '0;
    assign cache_hit = 1'b0;
  end

  // Outputs
  logic [63:0] mul_res;
  logic [31:0] result;
  logic        done;

  assign mul_res = mul_pipe_q[MUL_STAGES-1];
  assign done    = (state_q == S_DONE);

  always_comb begin
    result = '0;
    if (f3_q[2])                result = f3_q[1] ? rem_res_q : quo_res_q;
    else if (f3_q[1:0] == 2'b00) result = mul_res[31:0];
    else                        result = mul_res[63:32];
  end

  assign pcpi.ready = done;
  assign pcpi.wr    = done;
  assign pcpi.rd    = done ? result : 32'd0;
  assign pcpi.busy  = (state_q == S_MUL) || (state_q == S_DIV) ||
                      (state_q == S_FAST) || (state_q == S_DONE);

endmodule

// File: doc/riscv_m_unit_param.md
Name: riscv_m_unit_param

Overview:
Parametrised next-generation RV32M coprocessor on the PCPI handshake. It executes all eight M-extension instructions:
- multiplier with configurable pipeline depth;
- radix-configurable restoring divider;
- fast paths for divide-by-zero, signed overflow and early-out;
- optional quotient/remainder reuse cache, so a DIV followed by a REM on the same operands (or vice versa) returns in minimum latency.

It attaches to the host core's PCPI port in place of the single-generation M unit.

Parameters:
MUL_STAGES, 1, multiplier pipeline register stages between operand capture and result (legal 1..4).
DIV_BITS, 1, quotient bits resolved per divide iteration (legal 1, 2, 4).
ENABLE_EARLY_OUT, 1, when 1, |dividend| < |divisor| takes the fast path.
ENABLE_REUSE, 1, when 1, the quotient/remainder reuse cache is instantiated.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
valid  in  1  PCPI request valid; host holds it high until ready
instruction  in  32  instruction word
rs1  in  32  operand 1
rs2  in  32  operand 2
wr  out  1  write rd to register file; equal to ready
rd  out  32  result; 0 whenever ready=0
busy  out  1  unit owns the current instruction
ready  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous, active-low.
- Reset values: busy=0, ready=0, wr=0, rd=0; state=IDLE; cache invalid; all datapath registers 0. Assertion mid-operation aborts immediately and produces no ready.
- Decode: hit when opcode==0110011 and funct7==0000001. funct3 selects the operation:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU;
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - Non-hit with valid=1: the unit never asserts busy or ready.
- Accept: edge t0 is the clock edge at which state==IDLE, valid=1 and decode hit.
  - rs1, rs2 and funct3 are captured at t0.
  - busy=1 from cycle t0+1 through the ready cycle inclusive.
- States and transitions:
  - IDLE: accept -> MUL, DIV or FAST.
  - MUL: after MUL_STAGES cycles -> DONE.
  - DIV: after 32/DIV_BITS iterations plus one sign-fixup cycle -> DONE.
  - FAST: 1 cycle -> DONE.
  - DONE: ready=wr=1 and rd valid for exactly one cycle -> COOL.
  - COOL: busy=0 and valid is ignored for one cycle -> IDLE. This prevents re-triggering on the host's trailing valid.
- Latency (ready high in cycle):
  - MUL*: t0+MUL_STAGES+1.
  - Full divide: t0+32/DIV_BITS+2.
  - Fast path: t0+2.
- Multiply: 33x33 signed product of sign- or zero-extended operands.
  - MUL returns product[31:0].
  - MULH, MULHSU, MULHU return product[63:32].
  - Extension: MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
- Divide: operates on magnitudes (signed ops take abs of both operands). Fixup step:
  - quotient is negated when the operand signs differ;
  - remainder takes the sign of the dividend.
- Fast paths, evaluated in priority order at t0:
  1. rs2==0: quotient=0xFFFFFFFF, remainder=rs1.
  2. Signed op with rs1==0x80000000 and rs2==0xFFFFFFFF: quotient=0x80000000, remainder=0.
  3. Reuse hit: cache valid, same rs1, same rs2, same signedness (DIV/REM signed; DIVU/REMU unsigned). Returns the cached quotient or remainder.
  4. ENABLE_EARLY_OUT and |rs1|<|rs2| (unsigned compare of magnitudes): quotient=0, remainder=rs1.
- Reuse cache:
  - Written on every completed divide-class op, both full and fast path: rs1, rs2, signedness, quotient, remainder.
  - MUL ops leave it untouched. It is invalidated only by reset.
  - With ENABLE_REUSE=0, hit is constant 0.
- valid falls while busy: abort to IDLE on the next edge; no ready pulse; cache is not written.
- Internal arithmetic is 64 bits wide for the multiplier and 32-bit remainder/divisor/quotient for the divider. No output depends on X.

Test Plan:
- MUL_STAGES=2; MULH rs1=0xFFFFFFFF (-1), rs2=0x00000002 -> ready at t0+3, rd=0xFFFFFFFF, wr=1 for one cycle; MULHU with the same operands -> rd=0x00000001.
- DIV_BITS=1, EARLY_OUT=0; DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> ready at t0+34, rd=0xFFFFFFFD (-3); REM with the same operands -> fast (t0+2), rd=0xFFFFFFFF (-1).
- DIVU rs1=100, rs2=0 -> ready at t0+2, rd=0xFFFFFFFF; REMU rs1=100, rs2=0 -> rd=100. DIV rs1=0x80000000, rs2=0xFFFFFFFF -> rd=0x80000000; REM with the same operands -> rd=0.
- DIV_BITS=4, EARLY_OUT=1; DIVU 5/9 -> ready at t0+2, rd=0; DIVU 0xFFFFFFFF/3 -> ready at t0+10, rd=0x55555555. Non-M instruction (funct7=0) with valid held 20 cycles -> busy and ready never assert.
- Drop valid at t0+5 during DIV -> no ready, next cycle IDLE; subsequent REM with the same operands takes the full divide (cache not written). resetn low at t0+3 of MUL -> outputs 0 immediately, no ready.
- Back-to-back: host holds valid one cycle after ready -> COOL ignores it, no second accept; new valid in IDLE accepted normally.
